fetch_iq: RTL and testbench
===========================

# fetch_iq

Parametrised instruction queue between the fetch stage and decode. It buffers fetched instructions with their PC, compressed flag and branch-prediction info, so the PC/icache side keeps running while decode stalls. Its enqueue side takes the fetch output (pc, expanded inst, is_comp, spec). Its dequeue side feeds the IF/ID boundary. A redirect flush empties it in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, 2..16
- XLEN, package value (32), PC and instruction width

Ports:
- clk_i  in  1  core clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-high (asserted = 1)
- flush_i  in  1  redirect/mispredict flush; empties queue
- enq_valid_i  in  1  fetch has a valid instruction
- enq_ready_o  out  1  queue can accept this cycle
- enq_pc_i  in  XLEN  PC of instruction
- enq_inst_i  in  XLEN  expanded 32-bit instruction
- enq_comp_i  in  1  original was compressed
- enq_spec_i  in  predict_info_t  prediction (taken, target pc)
- deq_valid_o  out  1  head entry valid
- deq_ready_i  in  1  decode consumes head
- deq_pc_o  out  XLEN  head PC
- deq_inst_o  out  XLEN  head instruction
- deq_comp_o  out  1  head compressed flag
- deq_spec_o  out  predict_info_t  head prediction
- count_o  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Storage: DEPTH-entry flop array of iq_entry_t. Read pointer and write pointer are each $clog2(DEPTH)+1 bits. The extra MSB distinguishes full from empty.
- Enqueue fires when enq_valid_i && enq_ready_o. The entry is written at wr_ptr and wr_ptr increments.
- Dequeue fires when deq_valid_o && deq_ready_i. rd_ptr increments.
- Empty when the pointers are equal.
- Full when the low bits are equal and the MSBs differ.
- Pointers wrap naturally modulo 2*DEPTH. Index = low bits.
- enq_ready_o = !full. It has no combinational dependence on deq_ready_i. A full queue refuses enqueue even if a dequeue happens in the same cycle.
- deq_valid_o = !empty, except as modified by bypass (Configuration).
- The deq_* data outputs show entry[rd_ptr]. They are forced to 0 when deq_valid_o = 0.
- Simultaneous enqueue and dequeue on a non-empty, non-full queue: count_o unchanged, both pointers advance.
- count_o = wr_ptr - rd_ptr, computed in pointer width.
- flush_i has priority over everything:
  - rd_ptr and wr_ptr go to 0.
  - Any enqueue or dequeue in that cycle is discarded.
  - enq_ready_o stays combinationally = !full during flush. The source sees an accept, but the data is dropped.
- Reset (rst_ni = 1, async): pointers = 0, count_o = 0, deq_valid_o = 0, deq_* = 0, enq_ready_o = 1 once released.
- Reset asserted mid-operation clears the queue immediately, regardless of clk_i.
- Storage array is not reset. Read data is masked by deq_valid_o.

## Timing
- Enqueue-to-dequeue latency without bypass: 1 cycle. An entry written at edge N is visible on deq_* after edge N.
- With bypass (empty queue): 0 cycles.
- Sustained throughput: one instruction per cycle in each direction.
- After a flush edge, deq_valid_o = 0 and enq_ready_o = 1 in the following cycle.
- No output is registered separately; all outputs are decoded from the pointers and storage.

## Configuration
- Macro: FETCH_IQ_BYPASS_EN.
- Defined: when the queue is empty, enq_valid_i = 1 and flush_i = 0:
  - deq_valid_o = 1 and deq_* = enq_* combinationally.
  - If deq_ready_i = 1, the entry is consumed without being written and the pointers stay put.
  - If deq_ready_i = 0, the entry is written normally.
- Undefined: no enq→deq combinational path, latency is always ≥1 cycle.

## Structure
- tcore_param gains:
  - iq_entry_t (pc XLEN, inst XLEN, is_comp 1, spec predict_info_t)
  - localparam IQ_DEPTH = 4
- predict_info_t is reused unchanged.
- No sub-module. Pointer/flag logic and the storage array are inline in fetch_iq.

## Test plan
- Reset: hold rst_ni = 1 for 3 cycles mid-traffic → count_o = 0, deq_valid_o = 0, deq_pc_o = 0; after release enq_ready_o = 1.
- Fill: DEPTH = 4, enqueue pc 0x4000_0000, +4, +8, +C with deq_ready_i = 0 → count_o = 4, enq_ready_o = 0, deq_pc_o = 0x4000_0000. A 5th enq_valid_i is not accepted.
- Full with simultaneous dequeue: queue full, deq_ready_i = 1, enq_valid_i = 1 → only the dequeue fires, count_o = 3, next deq_pc_o = 0x4000_0004.
- Wrap-around: 10 back-to-back enqueues with deq_ready_i = 1 and compressed entries (pc step 2, enq_comp_i = 1) → dequeued PCs in order 0x4000_0000..0x4000_0012, count_o stays ≤1.
- Flush: 3 entries queued, flush_i = 1 with enq_valid_i = 1 → next cycle count_o = 0, deq_valid_o = 0, and the flush-cycle entry never appears.
- Bypass (FETCH_IQ_BYPASS_EN): empty queue, enq pc 0x4000_0100, deq_ready_i = 1 → deq_valid_o = 1 and deq_pc_o = 0x4000_0100 in the same cycle, count_o stays 0. Without the macro, it appears one cycle later.

Source files
------------

// File: rtl/tcore_param.sv
// Core-wide types and constants shared by the fetch front end.
//   XLEN            PC / instruction width
//   IQ_DEPTH        default instruction-queue depth
//   predict_info_t  branch prediction attached to a fetched instruction
//   iq_entry_t      one instruction-queue slot (pc, inst, is_comp, spec)
package tcore_param;

    localparam int XLEN     = 32;
    localparam int IQ_DEPTH = 4;

    typedef struct packed {
        logic            taken;
        logic [XLEN-1:0] target;
    } predict_info_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
        logic            is_comp;
        predict_info_t   spec;
    } iq_entry_t;

endpackage

// File: rtl/fetch_iq.sv
// fetch_iq: instruction queue between fetch and decode.
// Buffers fetched instructions (pc, expanded inst, compressed flag,
// prediction) so fetch keeps running while decode stalls. A flush empties
// the queue in one cycle.
//
// Optional feature: define FETCH_IQ_BYPASS_EN to add a same-cycle
// enq->deq path when the queue is empty.
//
// Ports:
//   clk_i        core clock, rising edge
//   rst_ni       asynchronous reset, active-high
//   flush_i      redirect flush; highest priority, drops all traffic
//   enq_valid_i  fetch presents an instruction
//   enq_ready_o  queue not full (independent of deq_ready_i)
//   enq_pc_i / enq_inst_i / enq_comp_i / enq_spec_i  incoming entry
//   deq_valid_o  head entry valid
//   deq_ready_i  decode consumes head
//   deq_pc_o / deq_inst_o / deq_comp_o / deq_spec_o  head entry, 0 when invalid
//   count_o      occupied entries
module fetch_iq
    import tcore_param::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int XLEN  = tcore_param::XLEN
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [XLEN-1:0]            enq_pc_i,
    input  logic [XLEN-1:0]            enq_inst_i,
    input  logic                       enq_comp_i,
    input  predict_info_t              enq_spec_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [XLEN-1:0]            deq_pc_o,
    output logic [XLEN-1:0]            deq_inst_o,
    output logic                       deq_comp_o,
    output predict_info_t              deq_spec_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH) + 1;   // extra MSB separates full from empty
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] ptr_diff;
    logic [PW-2:0] rd_idx;
    logic [PW-2:0] wr_idx;

    logic          empty;
    logic          full;
    logic          bypass;
    logic          enq_fire;
    logic          deq_fire;

    iq_entry_t     mem [DEPTH];
    iq_entry_t     enq_entry;
    iq_entry_t     head;
    iq_entry_t     deq_entry;

    assign rd_idx = rd_ptr[PW-2:0];
    assign wr_idx = wr_ptr[PW-2:0];

    assign empty = (rd_ptr == wr_ptr);
    assign full  = (rd_ptr[PW-2:0] == wr_ptr[PW-2:0]) &&
                   (rd_ptr[PW-1] != wr_ptr[PW-1]);

    always_comb begin
        enq_entry         = '0;
        enq_entry.pc      = enq_pc_i;
        enq_entry.inst    = enq_inst_i;
        enq_entry.is_comp = enq_comp_i;
        enq_entry.spec    = enq_spec_i;
    end

`ifdef FETCH_IQ_BYPASS_EN
    // Gated by reset so the head stays invalid while the queue is held clear.
    assign bypass = empty && enq_valid_i && !flush_i && !rst_ni;
`else
    assign bypass = 1'b0;
`endif

    // Full refuses enqueue even if the head leaves this cycle; this keeps
    // enq_ready_o free of any deq_ready_i path.
    assign enq_ready_o = !full;
    assign deq_valid_o = !empty || bypass;

    // A bypassed entry consumed in the same cycle is never written.
    assign enq_fire = enq_valid_i && enq_ready_o && !flush_i &&
                      !(bypass && deq_ready_i);
    assign deq_fire = deq_valid_o && deq_ready_i && !flush_i && !bypass;

    assign head      = bypass ? enq_entry : mem[rd_idx];
    assign deq_entry = deq_valid_o ? head : '0;

    assign deq_pc_o   = deq_entry.pc;
    assign deq_inst_o = deq_entry.inst;
    assign deq_comp_o = deq_entry.is_comp;
    assign deq_spec_o = deq_entry.spec;

    // Modulo-2*DEPTH difference is the occupancy directly.
    assign ptr_diff = wr_ptr - rd_ptr;
    assign count_o  = ptr_diff[CW-1:0];

    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (enq_fire) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq_fire) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage is not reset; every read is masked by deq_valid_o.
    always_ff @(posedge clk_i) begin
        if (enq_fire) begin
            mem[wr_idx] <= enq_entry;
        end
    end

endmodule

// File: tb/tb_fetch_iq.sv
// Testbench for fetch_iq (DEPTH = 4). Stimulus pushes expected entries into
// a scoreboard queue; an independent monitor pops and compares on every
// dequeue handshake. Build with or without FETCH_IQ_BYPASS_EN.
module tb_fetch_iq;
    import tcore_param::*;

`ifdef FETCH_IQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          flush = 1'b0;
    logic          enq_valid = 1'b0;
    logic          enq_ready;
    logic [31:0]   enq_pc = '0;
    logic [31:0]   enq_inst = '0;
    logic          enq_comp = 1'b0;
    predict_info_t enq_spec = '0;
    logic          deq_valid;
    logic          deq_ready = 1'b0;
    logic [31:0]   deq_pc;
    logic [31:0]   deq_inst;
    logic          deq_comp;
    predict_info_t deq_spec;
    logic [2:0]    count;

    int n_checks = 0;
    int n_fail   = 0;

    iq_entry_t exp_q[$];

    fetch_iq dut (
        .clk_i       (clk),
        .rst_ni      (rst),
        .flush_i     (flush),
        .enq_valid_i (enq_valid),
        .enq_ready_o (enq_ready),
        .enq_pc_i    (enq_pc),
        .enq_inst_i  (enq_inst),
        .enq_comp_i  (enq_comp),
        .enq_spec_i  (enq_spec),
        .deq_valid_o (deq_valid),
        .deq_ready_i (deq_ready),
        .deq_pc_o    (deq_pc),
        .deq_inst_o  (deq_inst),
        .deq_comp_o  (deq_comp),
        .deq_spec_o  (deq_spec),
        .count_o     (count)
    );

    always #5 clk = ~clk;

    function automatic iq_entry_t mk(input logic [31:0] pc, input logic comp);
        iq_entry_t e;
        e.pc          = pc;
        e.inst        = pc ^ 32'h1357_9bdf;
        e.is_comp     = comp;
        e.spec.taken  = pc[2];
        e.spec.target = pc + 32'h40;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every dequeue handshake must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && deq_valid && deq_ready && !flush) begin
            iq_entry_t got;
            iq_entry_t want;
            got.pc      = deq_pc;
            got.inst    = deq_inst;
            got.is_comp = deq_comp;
            got.spec    = deq_spec;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL deq_unexpected: got pc 0x%0h expected no dequeue at %0t", deq_pc, $time);
            end else begin
                want = exp_q.pop_front();
                if (got !== want) begin
                    n_fail++;
                    $display("FAIL deq_entry: got 0x%0h (pc 0x%0h) expected 0x%0h (pc 0x%0h) at %0t",
                             got, got.pc, want, want.pc, $time);
                end
            end
        end
    end

    // One cycle of stimulus; returns at the negedge so callers can check
    // the combinational outputs of that cycle.
    task automatic step(input logic ev, input logic [31:0] pc, input logic comp,
                        input logic dr, input logic fl, input logic exp_rdy);
        iq_entry_t e;
        @(posedge clk);
        #1;
        e         = mk(pc, comp);
        enq_valid = ev;
        enq_pc    = e.pc;
        enq_inst  = e.inst;
        enq_comp  = e.is_comp;
        enq_spec  = e.spec;
        deq_ready = dr;
        flush     = fl;
        if (ev && exp_rdy && !fl) exp_q.push_back(e);
        @(negedge clk);
        chk("enq_ready", {63'd0, enq_ready}, {63'd0, exp_rdy});
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("rst_deq_pc", {32'd0, deq_pc}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rel_enq_ready", {63'd0, enq_ready}, 64'd1);

        // Fill to DEPTH with decode stalled
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'h4000_0000 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 32'h4000_0010, 1'b0, 1'b0, 1'b0, 1'b0);   // 5th refused
        chk("fill_count", {61'd0, count}, 64'd4);
        chk("fill_deq_pc", {32'd0, deq_pc}, 64'h4000_0000);
        chk("fill_deq_valid", {63'd0, deq_valid}, 64'd1);

        // Full with simultaneous dequeue: only the dequeue fires
        step(1'b1, 32'h4000_0014, 1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("fulldeq_count", {61'd0, count}, 64'd3);
        chk("fulldeq_deq_pc", {32'd0, deq_pc}, 64'h4000_0004);

        // Drain
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("drain_count", {61'd0, count}, 64'd0);
        chk("drain_deq_valid", {63'd0, deq_valid}, 64'd0);

        // Wrap-around with compressed entries, decode always ready
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 32'h4000_0000 + 32'(2 * i), 1'b1, 1'b1, 1'b0, 1'b1);
            chk("wrap_count_le1", {63'd0, (count <= 3'd1)}, 64'd1);
        end
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("wrap_end_count", {61'd0, count}, 64'd0);
        chk("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

        // Flush with an enqueue in the flush cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h4000_0200 + 32'(4 * i), 1'b0, 1'b0, 1'b0, 1'b1);
        end
        step(1'b1, 32'h4000_0300, 1'b0, 1'b0, 1'b1, 1'b1);
        exp_q.delete();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("flush_count", {61'd0, count}, 64'd0);
        chk("flush_deq_valid", {63'd0, deq_valid}, 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);

        // Empty-queue enqueue: bypass shows it now, otherwise next cycle
        step(1'b1, 32'h4000_0100, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("byp_deq_valid", {63'd0, deq_valid}, {63'd0, BYP});
        chk("byp_deq_pc", {32'd0, deq_pc}, BYP ? 64'h4000_0100 : 64'd0);
        chk("byp_count", {61'd0, count}, 64'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("byp_next_deq_valid", {63'd0, deq_valid}, {63'd0, !BYP});
        chk("byp_next_deq_pc", {32'd0, deq_pc}, BYP ? 64'd0 : 64'h4000_0100);
        chk("byp_next_count", {61'd0, count}, BYP ? 64'd0 : 64'd1);
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("byp_end_count", {61'd0, count}, 64'd0);

        // Asynchronous reset in the middle of traffic
        step(1'b1, 32'h4000_0400, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 32'h4000_0404, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        enq_valid = 1'b1;
        enq_pc    = 32'h4000_0408;
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_deq_valid", {63'd0, deq_valid}, 64'd0);
        chk("arst_deq_pc", {32'd0, deq_pc}, 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rsthold_count", {61'd0, count}, 64'd0);
        chk("rsthold_deq_valid", {63'd0, deq_valid}, 64'd0);
        @(posedge clk);
        #1;
        rst       = 1'b0;
        enq_valid = 1'b0;
        @(negedge clk);
        chk("rstrel_enq_ready", {63'd0, enq_ready}, 64'd1);
        chk("rstrel_count", {61'd0, count}, 64'd0);
        chk("rstrel_deq_valid", {63'd0, deq_valid}, 64'd0);

        chk("final_sb_empty", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
